bm_step_lanes: RTL and testbench
================================

// Module: bm_step_lanes
// PURPOSE
//  One Berlekamp-Massey iteration over GF(2^m) with N internal multiplier lanes and its own control FSM.
//  It replaces the fixed-width step that depended on an external vector multiplier.
//  Adds reset, a busy/ready handshake and descending-chunk in-place update of sigma/beta.
//  Called 2t times per decode by the BM controller, which supplies d, l, delta and k.
// PARAMETERS
//  t       119  error-correcting capability; sigma/beta hold t+1 coefficients
//  m       13   GF(2^m) element width
//  N       20   multiplier lanes; C = ceil((t+1)/N) chunks processed per step
//  INV_LAT 1    latency (cycles) of the GF inverse from delta latch to delta^-1 valid
// PORTS
//  clk        in   1             clock, all logic on posedge
//  rst        in   1             synchronous, active-high reset
//  init       in   1             load sigma=1, beta=x (accepted only when ready)
//  start      in   1             begin one iteration (accepted only when ready and !init)
//  d_in       in   m             discrepancy d of this iteration
//  l_in       in   CLOG2(2t+1)   current LFSR length L
//  delta_in   in   m             previous nonzero discrepancy delta
//  k_in       in   CLOG2(2t+1)   iteration index k
//  ready      out  1             high in IDLE; start/init accepted only then
//  done       out  1             one-cycle pulse when sigma/beta/l/delta updated
//  sigma_out  out  m*(t+1)       sigma coefficients, coeff i at [m*i +: m]
//  l_out      out  CLOG2(2t+1)   updated L
//  delta_out  out  m             updated delta
// BEHAVIOUR
//  Reset: sigma=1, beta=x, l_out=0, delta_out=1, done=0, ready=1, FSM=IDLE. rst mid-step aborts; no done.
//  init and start in the same cycle: init wins, start dropped. Both ignored while !ready.
//  FSM IDLE->LATCH->INV (INV_LAT cycles)->MUL (C cycles)->WB (1 cycle)->IDLE. done asserts in WB.
//  Step latency L_STEP = 1 + INV_LAT + C + 1 cycles from start sample to done; ready returns the next cycle.
//  LATCH registers d, l, delta, k and cond = (d==0) | (k < 2*l). The comparison uses width CLOG2(2t+1)+1, so there is no overflow.
//  INV computes q = d * delta^-1. delta==0 forces q=0, so sigma is unchanged.
//  MUL issues chunks high to low, j = C-1..0, one chunk per cycle. Each lane computes q*beta[i] with a 1-cycle registered gf_mul.
//  Writeback of chunk j occurs while chunk j-1 multiplies, so lower sigma coefficients are still old when read.
//  Update: sigma'[i] = sigma[i] ^ q*beta[i].
//  beta'[i] = cond ? beta[i-1] : sigma_old[i-1], with beta'[0]=0.
//  Lanes beyond coefficient t (last partial chunk) are masked and their writes are discarded.
//  At done: l_out = cond ? l : k-l+1 (mod 2^width); delta_out = cond ? delta : d.
//  Outputs are held stable between done pulses.
// CONFIGURATION
//  BM_INV_FREE_EN defined: inversion-free BM; no INV state and no inverter; 2N multipliers.
//    With it: sigma'[i] = delta*sigma[i] ^ d*beta[i]; L_STEP = 1 + C + 1; delta==0 yields sigma' = d*beta.
//  BM_INV_FREE_EN undefined: classic form above; N multipliers plus one inverter with latency INV_LAT.
//  beta, l and delta update identically in both modes.
// STRUCTURE
//  Shared header bm_defs.vh: CLOG2 macro, C = (t+N)/N, FSM state encodings, coefficient width helpers.
//  Sub-module bm_lane_array: N (or 2N) gf_mul lanes with a lane-valid mask; this module keeps the FSM, chunk counter and registers.
//  Reuse the existing GF inverse and gf_mul blocks unchanged.
// TESTING
//  rst 3 cycles then init -> sigma_out=1, l_out=0, delta_out=1, ready=1, no done.
//  init; start d=1,delta=1,l=0,k=0 -> after L_STEP done: coeff0=1, coeff1=1, l_out=1, delta_out=1, beta=x.
//  start d=0,l=2,k=5 -> sigma unchanged, l_out=2, delta_out=delta_in, done exactly once at L_STEP.
//  start pulsed again 2 cycles after start -> ignored; single done; ready low throughout.
//  rst asserted in MUL chunk 3 -> no done; sigma=1, beta=x, ready next cycle.
//  2t=238 steps with random syndromes (t=119, m=13) -> sigma_out and L match C model in both macro builds.

Source files
------------

// File: rtl/bm_step_lanes_pkg.sv
// Shared sizes, FSM encoding, step operand bundle and GF(2^13)
// helpers for the Berlekamp-Massey step and its lane array.
package bm_step_lanes_pkg;

  localparam int T       = 119;
  localparam int M       = 13;
  localparam int N       = 20;
  localparam int INV_LAT = 1;

  localparam int NC  = T + 1;
  localparam int C   = (T + N) / N;
  localparam int CN  = C * N;
  localparam int LW  = $clog2(2 * T + 1);
  localparam int CW  = (C > 1) ? $clog2(C) : 1;
  localparam int IW  = $clog2(CN + 1);
  localparam int ILW = (INV_LAT > 1) ? $clog2(INV_LAT) : 1;

`ifdef BM_INV_FREE_EN
  localparam int L_STEP = 1 + C + 1;
`else
  localparam int L_STEP = 1 + INV_LAT + C + 1;
`endif

  typedef logic [M-1:0] gf_t;

  // x^13 + x^4 + x^3 + x + 1, top term implicit
  localparam gf_t POLY_LO = 13'h001B;
  // a^(2^m - 2) == a^-1 for nonzero a
  localparam gf_t INV_EXP = {{(M-1){1'b1}}, 1'b0};

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_INV,
    S_MUL,
    S_WB
  } state_e;

  typedef struct packed {
    gf_t           d;
    logic [LW-1:0] l;
    gf_t           delta;
    logic [LW-1:0] k;
  } step_t;

  function automatic gf_t gf_mul(gf_t a, gf_t b);
    gf_t r;
    gf_t s;
    r = '0;
    s = a;
    for (int i = 0; i < M; i++) begin
      if (b[i]) r = r ^ s;
      s = s[M-1] ? ((s << 1) ^ POLY_LO) : (s << 1);
    end
    return r;
  endfunction

  function automatic gf_t gf_inv(gf_t a);
    gf_t r;
    r = gf_t'(1);
    for (int i = M - 1; i >= 0; i--) begin
      r = gf_mul(r, r);
      if (INV_EXP[i]) r = gf_mul(r, a);
    end
    return r;
  endfunction

endpackage

// File: rtl/bm_step_lanes_lane_array.sv
// N registered GF multiplier lanes (2N with BM_INV_FREE_EN) for one
// coefficient chunk, with a mask for lanes beyond coefficient t.
// Ports: clk; en_i registers a new chunk; chunk_i chunk index;
//   a_i/x_i scalar and beta chunk; b_i/y_i delta and sigma chunk
//   (BM_INV_FREE_EN only); p_o lane products; vld_o lane-valid mask.
module bm_step_lanes_lane_array
  import bm_step_lanes_pkg::*;
(
  input  logic         clk,
  input  logic         en_i,
  input  logic [CW-1:0] chunk_i,
  input  gf_t          a_i,
  input  gf_t [N-1:0]  x_i,
`ifdef BM_INV_FREE_EN
  input  gf_t          b_i,
  input  gf_t [N-1:0]  y_i,
`endif
  output gf_t [N-1:0]  p_o,
  output logic [N-1:0] vld_o
);

  logic [N-1:0] lane_ok;
  gf_t [N-1:0]  p_d;
  gf_t [N-1:0]  p_q;
  logic [N-1:0] vld_q;

  always_comb begin
    for (int n = 0; n < N; n++) begin
      lane_ok[n] = (int'(chunk_i) * N + n) <= T;
`ifdef BM_INV_FREE_EN
      p_d[n] = lane_ok[n] ?
        (gf_mul(a_i, x_i[n]) ^ gf_mul(b_i, y_i[n])) : '0;
`else
      p_d[n] = lane_ok[n] ? gf_mul(a_i, x_i[n]) : '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (en_i) begin
      p_q   <= p_d;
      vld_q <= lane_ok;
    end
  end

  assign p_o   = p_q;
  assign vld_o = vld_q;

endmodule

// File: rtl/bm_step_lanes.sv
// One Berlekamp-Massey iteration over GF(2^13) using chunked lanes.
// BM_INV_FREE_EN selects the inversion-free update (no INV state).
// Ports: clk; rst sync active-high; init loads sigma=1, beta=x;
//   start begins a step with d_in, l_in, delta_in, k_in; ready high
//   in IDLE; done pulses in WB, updated sigma_out/l_out/delta_out
//   are visible from the following cycle and held until next step.
module bm_step_lanes
  import bm_step_lanes_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            init,
  input  logic            start,
  input  logic [M-1:0]    d_in,
  input  logic [LW-1:0]   l_in,
  input  logic [M-1:0]    delta_in,
  input  logic [LW-1:0]   k_in,
  output logic            ready,
  output logic            done,
  output logic [M*NC-1:0] sigma_out,
  output logic [LW-1:0]   l_out,
  output logic [M-1:0]    delta_out
);

  state_e state_q, state_d;
  step_t  op_q;
  logic   cond_q;

  logic [CW-1:0] chunk_q;
  logic          wb_vld_q;
  logic [CW-1:0] wb_j_q;

  gf_t sigma_q [CN];
  gf_t beta_q  [CN];

  logic [LW-1:0] l_q;
  gf_t           delta_q;

  logic acc_init;
  logic acc_start;
  logic issue;

  gf_t [N-1:0]  lane_beta;
  gf_t [N-1:0]  prod;
  logic [N-1:0] prod_vld;
  gf_t          coef_a;

  logic [IW-1:0] wb_idx  [N];
  logic [IW-1:0] prv_idx [N];
  gf_t [N-1:0]   sig_wb;
  gf_t [N-1:0]   bet_wb;

`ifdef BM_INV_FREE_EN
  gf_t [N-1:0] lane_sigma;
`else
  gf_t          q_q;
  logic [ILW-1:0] inv_cnt_q;
  logic          inv_last;
  assign inv_last = inv_cnt_q == ILW'(INV_LAT - 1);
`endif

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (acc_start) state_d = S_LATCH;
`ifdef BM_INV_FREE_EN
      S_LATCH: state_d = S_MUL;
      S_INV:   state_d = S_MUL;
`else
      S_LATCH: state_d = S_INV;
      S_INV:   if (inv_last) state_d = S_MUL;
`endif
      S_MUL:   if (chunk_q == '0) state_d = S_WB;
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // outputs; init has priority over start
  always_comb begin
    ready     = state_q == S_IDLE;
    done      = state_q == S_WB;
    issue     = state_q == S_MUL;
    acc_init  = ready & init;
    acc_start = ready & start & ~init;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      chunk_q  <= '0;
      wb_vld_q <= 1'b0;
      wb_j_q   <= '0;
      op_q     <= '0;
      cond_q   <= 1'b0;
    end else begin
      wb_vld_q <= issue;
      wb_j_q   <= chunk_q;
      // chunks go high to low so lower coefficients stay old
      if (issue) chunk_q <= chunk_q - CW'(1);
      else       chunk_q <= CW'(C - 1);
      if (acc_start)
        op_q <= '{d_in, l_in, delta_in, k_in};
      if (state_q == S_LATCH)
        cond_q <= (op_q.d == '0) |
                  ({1'b0, op_q.k} < {op_q.l, 1'b0});
    end
  end

`ifndef BM_INV_FREE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      inv_cnt_q <= '0;
      q_q       <= '0;
    end else if (state_q == S_INV) begin
      inv_cnt_q <= inv_cnt_q + ILW'(1);
      q_q <= (op_q.delta == '0) ? '0 :
             gf_mul(op_q.d, gf_inv(op_q.delta));
    end else begin
      inv_cnt_q <= '0;
    end
  end
  assign coef_a = q_q;
`else
  assign coef_a = op_q.d;
`endif

  always_comb begin
    for (int n = 0; n < N; n++) begin
      lane_beta[n] =
        beta_q[IW'(chunk_q) * IW'(N) + IW'(n)];
`ifdef BM_INV_FREE_EN
      lane_sigma[n] =
        sigma_q[IW'(chunk_q) * IW'(N) + IW'(n)];
`endif
    end
  end

  bm_step_lanes_lane_array u_lanes (
    .clk     (clk),
    .en_i    (issue),
    .chunk_i (chunk_q),
    .a_i     (coef_a),
    .x_i     (lane_beta),
`ifdef BM_INV_FREE_EN
    .b_i     (op_q.delta),
    .y_i     (lane_sigma),
`endif
    .p_o     (prod),
    .vld_o   (prod_vld)
  );

  // writeback of the chunk issued last cycle
  always_comb begin
    for (int n = 0; n < N; n++) begin
      wb_idx[n]  = IW'(wb_j_q) * IW'(N) + IW'(n);
      prv_idx[n] = (wb_idx[n] == '0) ? '0 :
                   wb_idx[n] - IW'(1);
`ifdef BM_INV_FREE_EN
      sig_wb[n] = prod[n];
`else
      sig_wb[n] = sigma_q[wb_idx[n]] ^ prod[n];
`endif
      bet_wb[n] = (wb_idx[n] == '0) ? '0 :
                  cond_q ? beta_q[prv_idx[n]] :
                           sigma_q[prv_idx[n]];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || acc_init) begin
      for (int i = 0; i < CN; i++) begin
        sigma_q[i] <= (i == 0) ? gf_t'(1) : '0;
        beta_q[i]  <= (i == 1) ? gf_t'(1) : '0;
      end
    end else if (wb_vld_q) begin
      for (int n = 0; n < N; n++) begin
        if (prod_vld[n]) begin
          sigma_q[wb_idx[n]] <= sig_wb[n];
          beta_q[wb_idx[n]]  <= bet_wb[n];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      l_q     <= '0;
      delta_q <= gf_t'(1);
    end else if (state_q == S_WB) begin
      l_q     <= cond_q ? op_q.l :
                 op_q.k - op_q.l + LW'(1);
      delta_q <= cond_q ? op_q.delta : op_q.d;
    end
  end

  always_comb begin
    sigma_out = '0;
    for (int i = 0; i < NC; i++)
      sigma_out[M*i +: M] = sigma_q[i];
  end

  assign l_out     = l_q;
  assign delta_out = delta_q;

endmodule

// File: tb/tb_bm_step_lanes.sv
// Bench for bm_step_lanes: directed steps, abort, then a full
// 2t-step BM run on random syndromes against a log-table model.
module tb_bm_step_lanes;
  import bm_step_lanes_pkg::*;

  localparam int Q = (1 << M) - 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            init;
  logic            start;
  logic [M-1:0]    d_in;
  logic [LW-1:0]   l_in;
  logic [M-1:0]    delta_in;
  logic [LW-1:0]   k_in;
  logic            ready;
  logic            done;
  logic [M*NC-1:0] sigma_out;
  logic [LW-1:0]   l_out;
  logic [M-1:0]    delta_out;

  int n_chk  = 0;
  int n_fail = 0;

  int gexp [Q];
  int glog [Q+1];
  int ms [NC];
  int mb [NC];
  int ml;
  int mdel;
  int syn [2*T+1];

  bm_step_lanes dut (
    .clk       (clk),
    .rst       (rst),
    .init      (init),
    .start     (start),
    .d_in      (d_in),
    .l_in      (l_in),
    .delta_in  (delta_in),
    .k_in      (k_in),
    .ready     (ready),
    .done      (done),
    .sigma_out (sigma_out),
    .l_out     (l_out),
    .delta_out (delta_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int gmul(int a, int b);
    if (a == 0 || b == 0) return 0;
    return gexp[(glog[a] + glog[b]) % Q];
  endfunction

  function automatic int ginv(int a);
    if (a == 0) return 0;
    return gexp[(Q - glog[a]) % Q];
  endfunction

  function automatic void model_init();
    for (int i = 0; i < NC; i++) begin
      ms[i] = (i == 0) ? 1 : 0;
      mb[i] = (i == 1) ? 1 : 0;
    end
  endfunction

  function automatic void model_step(int d, int l, int dl, int k);
    int  ns [NC];
    int  nb [NC];
    bit  cond;
    int  q;
    cond = (d == 0) || (k < 2 * l);
    q = gmul(d, ginv(dl));
    for (int i = 0; i < NC; i++) begin
`ifdef BM_INV_FREE_EN
      ns[i] = gmul(dl, ms[i]) ^ gmul(d, mb[i]);
`else
      ns[i] = ms[i] ^ gmul(q, mb[i]);
`endif
      nb[i] = (i == 0) ? 0 : (cond ? mb[i-1] : ms[i-1]);
    end
    for (int i = 0; i < NC; i++) begin
      ms[i] = ns[i];
      mb[i] = nb[i];
    end
    ml   = cond ? l : ((k - l + 1) & ((1 << LW) - 1));
    mdel = cond ? dl : d;
  endfunction

  task automatic check_state(input string tag);
    for (int i = 0; i < NC; i++)
      check($sformatf("%s c%0d", tag, i),
            64'(sigma_out[M*i +: M]), 64'(ms[i]));
    check({tag, " l"}, 64'(l_out), 64'(ml));
    check({tag, " delta"}, 64'(delta_out), 64'(mdel));
  endtask

  // extra: 1 pulses start, 2 pulses init, two cycles into the step
  task automatic do_step(input string tag, input int d, input int l,
                         input int dl, input int k, input int extra);
    int cyc;
    int nd;
    int at;
    @(negedge clk);
    d_in     = M'(d);
    l_in     = LW'(l);
    delta_in = M'(dl);
    k_in     = LW'(k);
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    nd  = 0;
    at  = 0;
    while (!ready && cyc < 40) begin
      if (done) begin
        nd++;
        at = cyc;
      end
      start = (extra == 1 && cyc == 2);
      init  = (extra == 2 && cyc == 2);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    init  = 1'b0;
    check({tag, " done_at"}, 64'(at), 64'(L_STEP));
    check({tag, " n_done"}, 64'(nd), 64'd1);
    check({tag, " ready_at"}, 64'(cyc), 64'(L_STEP + 1));
    model_step(d, l, dl, k);
    check_state(tag);
  endtask

  initial begin
    int x;
    int cyc;
    int nd;
    int d;
    x = 1;
    for (int i = 0; i < Q; i++) begin
      gexp[i] = x;
      glog[x] = i;
      x = x << 1;
      if ((x & (1 << M)) != 0) x = x ^ 'h201B;
    end

    rst = 1'b1; init = 1'b0; start = 1'b0;
    d_in = '0; l_in = '0; delta_in = '0; k_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_init();
    ml = 0;
    mdel = 1;
    check("rst ready", 64'(ready), 64'd1);
    check("rst done", 64'(done), 64'd0);
    check_state("rst");

    @(negedge clk); init = 1'b1;
    @(negedge clk); init = 1'b0;
    check("init ready", 64'(ready), 64'd1);
    check("init done", 64'(done), 64'd0);
    check_state("init");

    do_step("first", 1, 0, 1, 0, 0);
    check("first c0", 64'(sigma_out[0 +: M]), 64'd1);
    check("first c1", 64'(sigma_out[M +: M]), 64'd1);
    check("first l1", 64'(l_out), 64'd1);
    check("first dl1", 64'(delta_out), 64'd1);

    do_step("dzero", 0, 2, 'h5A5, 5, 1);
    check("dzero l2", 64'(l_out), 64'd2);
    check("dzero dl", 64'(delta_out), 64'h5A5);

    do_step("delta0", 'h123, 1, 0, 3, 0);
    do_step("midinit", 'h7, 1, 'h3, 2, 2);
    for (int s = 0; s < 6; s++)
      do_step($sformatf("rnd%0d", s), $urandom_range(0, Q),
              $urandom_range(0, 10), $urandom_range(1, Q),
              $urandom_range(0, 20), 0);

    // init and start together: init wins
    @(negedge clk);
    init = 1'b1; start = 1'b1;
    @(negedge clk);
    init = 1'b0; start = 1'b0;
    check("both ready", 64'(ready), 64'd1);
    nd = 0;
    repeat (L_STEP + 1) begin
      if (done) nd++;
      @(negedge clk);
    end
    check("both n_done", 64'(nd), 64'd0);
    model_init();
    check_state("both");

    // abort while chunk 3 multiplies
    @(negedge clk);
    d_in = M'(13'h1F0); l_in = LW'(1);
    delta_in = M'(13'h2); k_in = LW'(4);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    nd = 0;
    while (cyc < L_STEP - 4) begin
      if (done) nd++;
      @(negedge clk);
      cyc++;
    end
    check("abort busy", 64'(ready), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort n_done", 64'(nd), 64'd0);
    check("abort ready", 64'(ready), 64'd1);
    check("abort done", 64'(done), 64'd0);
    model_init();
    ml = 0;
    mdel = 1;
    check_state("abort");

    // full decode on random syndromes
    @(negedge clk); init = 1'b1;
    @(negedge clk); init = 1'b0;
    model_init();
    for (int s = 1; s <= 2 * T; s++)
      syn[s] = $urandom_range(0, Q);
    for (int k = 0; k < 2 * T; k++) begin
      d = 0;
      for (int i = 0; i <= k && i < NC; i++)
        d = d ^ gmul(ms[i], syn[k + 1 - i]);
      do_step($sformatf("bm%0d", k), d, ml, mdel, k, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
